// File: rtl/long_fifo_rd_stream_pkg.sv
// Shared constants for the long FIFO read-side stream adapter.
// The block is family-independent, so this holds only widths common to its users.
package long_fifo_rd_stream_pkg;

    localparam int unsigned WORD_COUNT_W = 32;

endpackage

// File: rtl/long_fifo_rd_stream.sv
// Drains a standard-mode FIFO read port (dout one cycle after rd_en) into a valid/ready
// stream through a small prefetch ring; fifo_rd_en never depends on out_tready.
module long_fifo_rd_stream
    import long_fifo_rd_stream_pkg::*;
#(
    parameter int DSIZE = 10,
    parameter int DEPTH = 4
) (
    input  logic                         clock,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         fifo_empty,
    input  logic [DSIZE-1:0]             fifo_dout,
    output logic                         fifo_rd_en,
    output logic [DSIZE-1:0]             out_tdata,
    output logic                         out_tvalid,
    input  logic                         out_tready,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    output logic [WORD_COUNT_W-1:0]      word_count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [OW:0]   DEPTH_C  = (OW + 1)'(DEPTH);

    logic [OW-1:0]             r_occ;
    logic                      r_inflight;
    logic                      r_drop;
    logic [PW-1:0]             r_wp;
    logic [PW-1:0]             r_rp;
    logic [DSIZE-1:0]          r_buf [DEPTH];
    logic [WORD_COUNT_W-1:0]   r_word_count;

    logic                      w_capture;
    logic                      w_handshake;
    logic [OW:0]               w_credit;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    // Credit counts the word still on its way from the FIFO so the ring can never overflow.
    assign w_credit    = {1'b0, r_occ} + {{OW{1'b0}}, r_inflight};
    assign fifo_rd_en  = !fifo_empty && (w_credit < DEPTH_C) && !flush && rst_n;

    assign out_tvalid  = (r_occ != '0);
    assign out_tdata   = out_tvalid ? r_buf[r_rp] : '0;
    assign w_capture   = r_inflight && !r_drop;
    assign w_handshake = out_tvalid && out_tready;
    assign occupancy   = r_occ;
    assign word_count  = r_word_count;

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            r_occ        <= '0;
            r_inflight   <= 1'b0;
            r_drop       <= 1'b0;
            r_wp         <= '0;
            r_rp         <= '0;
            r_word_count <= '0;
        end else begin
            r_inflight <= fifo_rd_en;
            if (w_handshake) begin
                r_word_count <= r_word_count + WORD_COUNT_W'(1);
            end
            if (flush) begin
                r_occ  <= '0;
                r_wp   <= '0;
                r_rp   <= '0;
                r_drop <= r_inflight;
            end else begin
                r_drop <= 1'b0;
                if (w_capture) begin
                    r_wp <= ptr_inc(r_wp);
                end
                if (w_handshake) begin
                    r_rp <= ptr_inc(r_rp);
                end
                case ({w_capture, w_handshake})
                    2'b10:   r_occ <= r_occ + OW'(1);
                    2'b01:   r_occ <= r_occ - OW'(1);
                    default: r_occ <= r_occ;
                endcase
            end
        end
    end

    // Ring storage needs no reset; out_tdata is masked while nothing is buffered.
    always_ff @(posedge clock) begin
        if (w_capture) begin
            r_buf[r_wp] <= fifo_dout;
        end
    end

endmodule

// File: tb/tb_long_fifo_rd_stream.sv
// Self-checking bench: FIFO queue model feeding the adapter, scoreboard of popped words,
// and a DEPTH=2 instance for the reduced-throughput build.
module tb_long_fifo_rd_stream;

    localparam int DSIZE = 10;
    localparam int DEPTH = 4;

    logic              clock = 1'b0;
    logic              rst_n;
    logic              flush;
    logic              fifo_empty;
    logic [DSIZE-1:0]  fifo_dout;
    logic              fifo_rd_en;
    logic [DSIZE-1:0]  out_tdata;
    logic              out_tvalid;
    logic              out_tready;
    logic [2:0]        occupancy;
    logic [31:0]       word_count;

    logic              d2_flush;
    logic              d2_empty;
    logic [DSIZE-1:0]  d2_dout;
    logic              d2_rd_en;
    logic [DSIZE-1:0]  d2_tdata;
    logic              d2_tvalid;
    logic              d2_tready;
    logic [1:0]        d2_occupancy;
    logic [31:0]       d2_word_count;

    always #5 clock = ~clock;

    long_fifo_rd_stream #(.DSIZE(DSIZE), .DEPTH(DEPTH)) dut (
        .clock(clock), .rst_n(rst_n), .flush(flush), .fifo_empty(fifo_empty),
        .fifo_dout(fifo_dout), .fifo_rd_en(fifo_rd_en), .out_tdata(out_tdata),
        .out_tvalid(out_tvalid), .out_tready(out_tready), .occupancy(occupancy),
        .word_count(word_count)
    );

    long_fifo_rd_stream #(.DSIZE(DSIZE), .DEPTH(2)) dut2 (
        .clock(clock), .rst_n(rst_n), .flush(d2_flush), .fifo_empty(d2_empty),
        .fifo_dout(d2_dout), .fifo_rd_en(d2_rd_en), .out_tdata(d2_tdata),
        .out_tvalid(d2_tvalid), .out_tready(d2_tready), .occupancy(d2_occupancy),
        .word_count(d2_word_count)
    );

    int total = 0;
    int bad   = 0;

    logic [DSIZE-1:0] fifo_q[$];
    logic [DSIZE-1:0] exp_q[$];

    int  ready_pct   = 0;
    int  empty_pct   = 0;
    bit  force_empty = 1'b1;
    bit  flush_req   = 1'b0;
    bit  rst_req     = 1'b1;
    bit  chk_en      = 1'b0;

    bit               s_rd, s_hs, s_valid, s_flush, s_rst;
    logic [DSIZE-1:0] s_data;
    int               s_occ;
    bit               p_valid, p_hs, p_flush, p_rst;
    logic [DSIZE-1:0] p_data;
    logic [31:0]      wc_model = '0;

    int               d2_pop = 0;
    int               d2_lim = 0;
    bit               s2_rd, s2_hs;
    logic [DSIZE-1:0] s2_data;

    // One clock cycle: update FIFO models and inputs just after the edge, sample mid-cycle.
    task automatic tick();
        logic [DSIZE-1:0] e;
        @(posedge clock);
        #1;
        if (s_rd && fifo_q.size() > 0) begin
            fifo_dout = fifo_q.pop_front();
            exp_q.push_back(fifo_dout);
        end
        if (s2_rd) begin
            d2_dout = DSIZE'(d2_pop);
            d2_pop++;
        end
        out_tready = ($urandom_range(0, 99) < ready_pct);
        flush      = flush_req;
        rst_n      = !rst_req;
        fifo_empty = force_empty || (fifo_q.size() == 0) || ($urandom_range(0, 99) < empty_pct);
        d2_empty   = (d2_pop >= d2_lim);
        @(negedge clock);
        p_valid = s_valid; p_hs = s_hs; p_flush = s_flush; p_rst = s_rst; p_data = s_data;
        s_rd    = fifo_rd_en;
        s_valid = out_tvalid;
        s_hs    = out_tvalid && out_tready;
        s_data  = out_tdata;
        s_occ   = int'(occupancy);
        s_flush = flush;
        s_rst   = !rst_n;
        s2_rd   = d2_rd_en;
        s2_hs   = d2_tvalid && d2_tready;
        s2_data = d2_tdata;
        if (chk_en) begin
            total++;
            if (word_count !== wc_model) begin
                bad++; $display("FAIL word_count: got %0d want %0d", word_count, wc_model);
            end
            total++;
            if (s_occ > DEPTH) begin
                bad++; $display("FAIL occupancy_bound: got %0d want <= %0d", s_occ, DEPTH);
            end
            if (p_valid && !p_hs && !p_flush && !p_rst) begin
                total++;
                if (!s_valid || s_data !== p_data) begin
                    bad++;
                    $display("FAIL valid_hold: got valid=%0b data=%0h want valid=1 data=%0h",
                             s_valid, s_data, p_data);
                end
            end
            if (s_hs && !s_rst) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL scoreboard_extra: got %0h want none", s_data);
                end else begin
                    e = exp_q.pop_front();
                    if (s_data !== e) begin
                        bad++; $display("FAIL scoreboard_data: got %0h want %0h", s_data, e);
                    end
                end
            end
        end
        if (s_rst) begin
            wc_model = '0;
            exp_q.delete();
        end else begin
            if (s_hs) wc_model = wc_model + 32'd1;
            if (s_flush) exp_q.delete();
        end
    endtask

    task automatic drain(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < max_cyc; n++) begin
            tick();
            if (fifo_q.size() == 0 && exp_q.size() == 0 && s_occ == 0 && !s_rd) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bit ok;
        rst_req = 1'b1; force_empty = 1'b0; ready_pct = 0;
        fifo_q.push_back(10'h155);
        repeat (3) tick();
        total++;
        if (s_rd !== 1'b0) begin
            bad++; $display("FAIL reset_rd_en: got %0b want 0", s_rd);
        end
        rst_req = 1'b0;
        tick();
        total++;
        if (s_valid !== 1'b0 || s_data !== '0 || s_occ != 0 || word_count !== 32'd0) begin
            bad++;
            $display("FAIL reset_outputs: got valid=%0b data=%0h occ=%0d wc=%0d want all 0",
                     s_valid, s_data, s_occ, word_count);
        end
        total++;
        if (s_rd !== 1'b1) begin
            bad++; $display("FAIL post_reset_rd_en: got %0b want 1", s_rd);
        end
        chk_en = 1'b1;
        ready_pct = 100;
        drain(20, ok);
        total++;
        if (!ok) begin
            bad++; $display("FAIL reset_drain: got left=%0d want 0", exp_q.size());
        end
    endtask

    task automatic test_streaming();
        int          lat;
        int          run;
        logic [31:0] wc_base;
        wc_base = wc_model;
        force_empty = 1'b1; ready_pct = 100; empty_pct = 0;
        for (int i = 0; i < 100; i++) fifo_q.push_back(DSIZE'(i));
        tick();
        force_empty = 1'b0;
        lat = -1;
        // Sample 0 is the cycle in which fifo_empty is first low.
        for (int n = 0; n < 10; n++) begin
            tick();
            if (s_valid) begin
                lat = n;
                break;
            end
        end
        total++;
        if (lat != 2) begin
            bad++; $display("FAIL stream_latency: got %0d want 2", lat);
        end
        run = s_hs ? 1 : 0;
        for (int n = 0; n < 150 && run < 100; n++) begin
            tick();
            if (!s_hs) break;
            run++;
        end
        total++;
        if (run != 100) begin
            bad++; $display("FAIL stream_back_to_back: got %0d want 100", run);
        end
        tick();
        total++;
        if (word_count !== wc_base + 32'd100 || s_valid !== 1'b0) begin
            bad++;
            $display("FAIL stream_word_count: got %0d valid=%0b want %0d valid=0",
                     word_count, s_valid, wc_base + 32'd100);
        end
    endtask

    task automatic test_backpressure();
        int               pulses;
        bit               stable;
        bit               ok;
        logic [DSIZE-1:0] head;
        ready_pct = 0; force_empty = 1'b1;
        for (int i = 0; i < 20; i++) fifo_q.push_back(DSIZE'($urandom));
        tick();
        head = fifo_q[0];
        force_empty = 1'b0;
        pulses = 0; stable = 1'b1;
        for (int n = 0; n < 10; n++) begin
            tick();
            if (s_rd) pulses++;
            if (s_valid && s_data !== head) stable = 1'b0;
        end
        total++;
        if (pulses != 4) begin
            bad++; $display("FAIL bp_rd_pulses: got %0d want 4", pulses);
        end
        total++;
        if (s_occ != 4) begin
            bad++; $display("FAIL bp_occupancy: got %0d want 4", s_occ);
        end
        total++;
        if (!stable || !s_valid || s_data !== head) begin
            bad++; $display("FAIL bp_head_stable: got %0h want %0h", s_data, head);
        end
        ready_pct = 100;
        drain(100, ok);
        total++;
        if (!ok) begin
            bad++; $display("FAIL bp_drain: got left=%0d want 0", exp_q.size());
        end
    endtask

    task automatic test_flush();
        bit               found;
        bit               ok;
        logic [DSIZE-1:0] next_word;
        ready_pct = 0; force_empty = 1'b1;
        for (int i = 0; i < 12; i++) fifo_q.push_back(DSIZE'($urandom));
        tick();
        force_empty = 1'b0;
        found = 1'b0;
        for (int n = 0; n < 12; n++) begin
            tick();
            if (s_occ == 2 && s_rd) begin
                found = 1'b1;
                break;
            end
        end
        total++;
        if (!found) begin
            bad++; $display("FAIL flush_setup: got occ=%0d want 2 with read", s_occ);
        end
        flush_req = 1'b1;
        tick();
        total++;
        if (s_occ != 3 || s_rd !== 1'b0) begin
            bad++; $display("FAIL flush_cycle: got occ=%0d rd=%0b want occ=3 rd=0", s_occ, s_rd);
        end
        next_word = fifo_q[0];
        flush_req = 1'b0;
        tick();
        total++;
        if (s_occ != 0 || s_valid !== 1'b0) begin
            bad++; $display("FAIL flush_clear: got occ=%0d valid=%0b want 0 0", s_occ, s_valid);
        end
        ready_pct = 100;
        found = 1'b0;
        for (int n = 0; n < 10; n++) begin
            if (s_valid) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        total++;
        if (!found || s_data !== next_word) begin
            bad++; $display("FAIL flush_next_word: got %0h want %0h", s_data, next_word);
        end
        drain(100, ok);
        total++;
        if (!ok) begin
            bad++; $display("FAIL flush_drain: got left=%0d want 0", exp_q.size());
        end
    endtask

    task automatic test_bubbling();
        logic [31:0] wc_base;
        bit          ok;
        wc_base = wc_model;
        ready_pct = 50; empty_pct = 50; force_empty = 1'b0;
        for (int i = 0; i < 10000; i++) fifo_q.push_back(DSIZE'($urandom));
        drain(60000, ok);
        total++;
        if (!ok) begin
            bad++; $display("FAIL bubble_drain: got left=%0d want 0", fifo_q.size() + exp_q.size());
        end
        total++;
        if (wc_model - wc_base != 32'd10000) begin
            bad++; $display("FAIL bubble_count: got %0d want 10000", wc_model - wc_base);
        end
        empty_pct = 0; ready_pct = 100;
    endtask

    task automatic test_reset_mid();
        bit ok;
        ready_pct = 100; force_empty = 1'b0;
        for (int i = 0; i < 50; i++) fifo_q.push_back(DSIZE'(500 + i));
        repeat (8) tick();
        rst_req = 1'b1;
        tick();
        total++;
        if (s_rd !== 1'b0) begin
            bad++; $display("FAIL midreset_rd_en: got %0b want 0", s_rd);
        end
        rst_req = 1'b0;
        fifo_q.delete();
        tick();
        total++;
        if (s_valid !== 1'b0 || s_data !== '0 || s_occ != 0 || word_count !== 32'd0 || s_rd !== 1'b0) begin
            bad++;
            $display("FAIL midreset_outputs: got valid=%0b data=%0h occ=%0d wc=%0d rd=%0b want all 0",
                     s_valid, s_data, s_occ, word_count, s_rd);
        end
        for (int i = 0; i < 20; i++) fifo_q.push_back(DSIZE'(700 + i));
        drain(100, ok);
        total++;
        if (!ok || wc_model != 32'd20) begin
            bad++; $display("FAIL midreset_restream: got %0d want 20", wc_model);
        end
    endtask

    task automatic test_depth2();
        int  got;
        int  gap;
        bit  gap_bad;
        d2_lim = 40;
        got = 0; gap = 0; gap_bad = 1'b0;
        for (int n = 0; n < 200 && got < 40; n++) begin
            tick();
            if (s2_hs) begin
                total++;
                if (s2_data !== DSIZE'(got)) begin
                    bad++; $display("FAIL d2_data: got %0h want %0h", s2_data, DSIZE'(got));
                end
                got++;
                gap = 0;
            end else if (got > 0) begin
                gap++;
                if (gap > 1) gap_bad = 1'b1;
            end
            if (d2_occupancy > 2'd2) gap_bad = 1'b1;
        end
        total++;
        if (got != 40 || gap_bad) begin
            bad++; $display("FAIL d2_throughput: got words=%0d stall=%0b want 40 0", got, gap_bad);
        end
        tick();
        total++;
        if (d2_word_count !== 32'd40) begin
            bad++; $display("FAIL d2_word_count: got %0d want 40", d2_word_count);
        end
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; fifo_empty = 1'b1; fifo_dout = '0; out_tready = 1'b0;
        d2_flush = 1'b0; d2_empty = 1'b1; d2_dout = '0; d2_tready = 1'b1;
        s_rd = 1'b0; s_hs = 1'b0; s_valid = 1'b0; s_flush = 1'b0; s_rst = 1'b1;
        s_data = '0; s_occ = 0; s2_rd = 1'b0; s2_hs = 1'b0; s2_data = '0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_bubbling();
        test_reset_mid();
        test_depth2();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
